// File: rtl/key_input_module_pkg.sv
// Shared definitions for the memory-mapped I/O devices on the processor bus.
package key_input_module_pkg;

  localparam logic [31:0] LEDG_ADDR          = 32'hF0000000;
  localparam logic [31:0] KDATA_ADDR_DEFAULT = 32'hF0000010;
  localparam logic [31:0] KCTRL_ADDR_DEFAULT = 32'hF0000110;

  localparam int READY_BIT   = 0;
  localparam int OVERRUN_BIT = 2;
  localparam int IE_BIT      = 8;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 10000;

  function automatic logic [31:0] kctrl_word(input logic ie, input logic overrun, input logic ready);
    logic [31:0] w;
    w              = '0;
    w[IE_BIT]      = ie;
    w[OVERRUN_BIT] = overrun;
    w[READY_BIT]   = ready;
    return w;
  endfunction

endpackage

// File: rtl/key_input_module_debouncer.sv
// Two-flop synchronizer plus one shared debounce counter for all keys.
// stable follows synced after DEBOUNCE_CYCLES equal samples; change pulses on that edge.
module key_debouncer #(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NKEYS-1:0] key_n,
  output logic [NKEYS-1:0] stable,
  output logic             change
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic [NKEYS-1:0] sync1_q, sync1_d;
  logic [NKEYS-1:0] sync2_q, sync2_d;
  logic [NKEYS-1:0] prev_q, prev_d;
  logic [NKEYS-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NKEYS-1:0] synced;
  logic             change_d;

  assign synced = ~sync2_q;

  // The edge where synced first takes a new value clears the counter, so the
  // accepting edge is the DEBOUNCE_CYCLES-th consecutive sample of that value.
  always_comb begin
    sync1_d  = key_n;
    sync2_d  = sync1_q;
    prev_d   = synced;
    stable_d = stable_q;
    cnt_d    = '0;
    change_d = 1'b0;
    if ((synced != stable_q) && (synced == prev_q)) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = synced;
        change_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      prev_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign change = change_d;

endmodule

// File: rtl/key_input_module.sv
// Pushbutton input device: debounced key data register plus Ready/Overrun/IE status.
// Registered read data with one-cycle latency; intr is a level request (Ready & IE).
module key_input_module
  import key_input_module_pkg::*;
#(
  parameter logic [31:0] KDATA_ADDR      = KDATA_ADDR_DEFAULT,
  parameter logic [31:0] KCTRL_ADDR      = KCTRL_ADDR_DEFAULT,
  parameter int          NKEYS           = 4,
  parameter int          DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      dbus,
  input  logic [31:0]      abus,
  input  logic             wren,
  input  logic [NKEYS-1:0] key_n,
  output logic [31:0]      dbusout,
  output logic             intr
);

  logic [NKEYS-1:0] stable;
  logic             change;
  logic             rd_kdata, rd_kctrl, wr_kctrl;
  logic             ready_q, ready_d;
  logic             overrun_q, overrun_d;
  logic             ie_q, ie_d;
  logic [31:0]      dbusout_q, dbusout_d;
  logic             unused_dbus;

  assign unused_dbus = ^{dbus[31:IE_BIT+1], dbus[IE_BIT-1:OVERRUN_BIT+1], dbus[OVERRUN_BIT-1:READY_BIT+1]};

  key_debouncer #(
    .NKEYS           (NKEYS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_n),
    .stable  (stable),
    .change  (change)
  );

  assign rd_kdata = !wren && (abus == KDATA_ADDR);
  assign rd_kctrl = !wren && (abus == KCTRL_ADDR);
  assign wr_kctrl =  wren && (abus == KCTRL_ADDR);

  // A new key event always wins over a clear landing on the same edge.
  always_comb begin
    ready_d   = ready_q;
    overrun_d = overrun_q;
    ie_d      = ie_q;
    if (rd_kdata) begin
      ready_d = 1'b0;
    end
    if (wr_kctrl) begin
      ie_d = dbus[IE_BIT];
      if (!dbus[READY_BIT])   ready_d   = 1'b0;
      if (!dbus[OVERRUN_BIT]) overrun_d = 1'b0;
    end
    if (change) begin
      ready_d = 1'b1;
      if (ready_q && !rd_kdata) overrun_d = 1'b1;
    end
  end

  always_comb begin
    dbusout_d = '0;
    if (rd_kdata) begin
      dbusout_d = 32'(stable);
    end else if (rd_kctrl) begin
      dbusout_d = kctrl_word(ie_q, overrun_q, ready_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      ie_q      <= 1'b0;
      dbusout_q <= '0;
    end else begin
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
      ie_q      <= ie_d;
      dbusout_q <= dbusout_d;
    end
  end

  assign dbusout = dbusout_q;
  assign intr    = ready_q & ie_q;

endmodule
